// File: rtl/colparity_seq_core.sv
// colparity_seq_core: lane/depth sequencing counters and 5-column parity
// generator for the ColParity datapath.
//   - lane counter: 0..LANES-1 with wrap, carry-out when at LANES-1
//   - depth counter: 0..2^DEPTH_W-1 with natural wrap, carry-out at all ones
//   - column parity over a 5x5 state (bit index = 5*y + x)
// Optional build macro COLPARITY_PARITY_REG_EN: when defined, parity_out is
// registered (1-cycle latency, cleared by rst); otherwise it is combinational.
module colparity_seq_core #(
  parameter int unsigned LANES   = 25,
  parameter int unsigned DEPTH_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [24:0]        state_in,
  output logic [4:0]         parity_out,
  input  logic               lane_en,
  input  logic               lane_clr,
  output logic [4:0]         lane_cnt,
  output logic               lane_co,
  input  logic               depth_en,
  input  logic               depth_clr,
  output logic [DEPTH_W-1:0] depth_cnt,
  output logic               depth_co
);

  localparam logic [4:0] LANE_LAST = 5'(LANES - 1);

  logic [4:0] col_par;

  // Lane counter: clear has priority over enable; wraps at LANES-1.
  always_ff @(posedge clk) begin
    if (rst || lane_clr) begin
      lane_cnt <= '0;
    end else if (lane_en) begin
      if (lane_cnt == LANE_LAST) lane_cnt <= '0;
      else                       lane_cnt <= lane_cnt + 5'd1;
    end
  end

  // Depth counter: clear has priority over enable; natural binary wrap.
  always_ff @(posedge clk) begin
    if (rst || depth_clr) begin
      depth_cnt <= '0;
    end else if (depth_en) begin
      depth_cnt <= depth_cnt + DEPTH_W'(1);
    end
  end

  // Carry-outs reflect the current count only, independent of the enables.
  always_comb begin
    lane_co  = (lane_cnt == LANE_LAST);
    depth_co = &depth_cnt;
  end

  // Column parity: XOR of the five rows in each column; X/Z propagate.
  always_comb begin
    col_par = '0;
    for (int unsigned y = 0; y < 5; y++) begin
      for (int unsigned x = 0; x < 5; x++) begin
        col_par[x] = col_par[x] ^ state_in[5*y + x];
      end
    end
  end

`ifdef COLPARITY_PARITY_REG_EN
  // Registered parity: loaded every clock, cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) parity_out <= '0;
    else     parity_out <= col_par;
  end
`else
  // Combinational parity: zero latency, no reset dependence.
  always_comb begin
    parity_out = col_par;
  end
`endif

endmodule

// File: tb/tb_colparity_seq_core.sv
// tb_colparity_seq_core: directed plan checks plus randomized stimulus
// against a behavioural reference model (modular counters, per-column
// popcount parity). Honours COLPARITY_PARITY_REG_EN for parity latency.
module tb_colparity_seq_core;

  localparam int unsigned LANES   = 25;
  localparam int unsigned DEPTH_W = 6;
  localparam int unsigned DEPTH_N = 1 << DEPTH_W;

  logic               clk = 1'b0;
  logic               rst;
  logic [24:0]        state_in;
  logic [4:0]         parity_out;
  logic               lane_en, lane_clr;
  logic [4:0]         lane_cnt;
  logic               lane_co;
  logic               depth_en, depth_clr;
  logic [DEPTH_W-1:0] depth_cnt;
  logic               depth_co;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state
  int unsigned m_lane  = 0;
  int unsigned m_depth = 0;
  logic [4:0]  m_par   = '0;

  colparity_seq_core #(.LANES(LANES), .DEPTH_W(DEPTH_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .state_in   (state_in),
    .parity_out (parity_out),
    .lane_en    (lane_en),
    .lane_clr   (lane_clr),
    .lane_cnt   (lane_cnt),
    .lane_co    (lane_co),
    .depth_en   (depth_en),
    .depth_clr  (depth_clr),
    .depth_cnt  (depth_cnt),
    .depth_co   (depth_co)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Column parity from the population count of each column's five bits.
  function automatic logic [4:0] ref_par(input logic [24:0] s);
    logic [4:0] p;
    logic [4:0] col;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) col[y] = s[5*y + x];
      p[x] = ($countones(col) % 2) == 1;
    end
    return p;
  endfunction

  // Apply one cycle of inputs, step the model, check all outputs after the edge.
  task automatic step(input logic r, input logic le, input logic lc,
                      input logic de, input logic dc, input logic [24:0] s);
    rst = r; lane_en = le; lane_clr = lc;
    depth_en = de; depth_clr = dc; state_in = s;
    #1;
`ifdef COLPARITY_PARITY_REG_EN
    check("par_hold", 32'(parity_out), 32'(m_par));
`else
    check("par_comb", 32'(parity_out), 32'(ref_par(s)));
`endif
    @(posedge clk);
    if (r || lc)   m_lane = 0;
    else if (le)   m_lane = (m_lane + 1) % LANES;
    if (r || dc)   m_depth = 0;
    else if (de)   m_depth = (m_depth + 1) % DEPTH_N;
`ifdef COLPARITY_PARITY_REG_EN
    m_par = r ? 5'b00000 : ref_par(s);
`else
    m_par = ref_par(s);
`endif
    #1;
    check("lane_cnt",  32'(lane_cnt),  m_lane);
    check("lane_co",   32'(lane_co),   32'(m_lane == LANES - 1));
    check("depth_cnt", 32'(depth_cnt), m_depth);
    check("depth_co",  32'(depth_co),  32'(m_depth == DEPTH_N - 1));
    check("parity",    32'(parity_out), 32'(m_par));
  endtask

  logic [24:0] pv_in  [5];
  logic [4:0]  pv_exp [5];

  initial begin
    rst = 1'b0; lane_en = 1'b0; lane_clr = 1'b0;
    depth_en = 1'b0; depth_clr = 1'b0; state_in = '0;
    @(posedge clk); #1;

    // Reset held two cycles with enables high
    step(1, 1, 0, 1, 0, 25'h0);
    step(1, 1, 0, 1, 0, 25'h0);
    check("rst_lane",  32'(lane_cnt), 0);
    check("rst_depth", 32'(depth_cnt), 0);
    check("rst_lco",   32'(lane_co), 0);
    check("rst_dco",   32'(depth_co), 0);
`ifdef COLPARITY_PARITY_REG_EN
    check("rst_par",   32'(parity_out), 0);
`endif

    // Lane sweep and wrap
    for (int i = 0; i < 24; i++) step(0, 1, 0, 0, 0, 25'h0);
    check("lane_top", 32'(lane_cnt), 24);
    check("lane_co1", 32'(lane_co), 1);
    step(0, 1, 0, 0, 0, 25'h0);
    check("lane_wrap", 32'(lane_cnt), 0);
    check("lane_co0",  32'(lane_co), 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 25'h0);
    step(0, 0, 0, 0, 0, 25'h0);
    step(0, 0, 0, 0, 0, 25'h0);
    check("lane_hold", 32'(lane_cnt), 10);
    step(0, 1, 1, 0, 0, 25'h0);
    check("lane_clr_pri", 32'(lane_cnt), 0);

    // Depth sweep, wrap, reset mid-count, clear priority
    for (int i = 0; i < 63; i++) step(0, 0, 0, 1, 0, 25'h0);
    check("depth_top", 32'(depth_cnt), 63);
    check("depth_co1", 32'(depth_co), 1);
    step(0, 0, 0, 1, 0, 25'h0);
    check("depth_wrap", 32'(depth_cnt), 0);
    check("depth_co0",  32'(depth_co), 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 25'h0);
    step(1, 0, 0, 1, 0, 25'h0);
    check("depth_rst", 32'(depth_cnt), 0);
    for (int i = 0; i < 37; i++) step(0, 0, 0, 1, 0, 25'h0);
    check("depth_37", 32'(depth_cnt), 37);
    step(0, 0, 0, 1, 1, 25'h0);
    check("depth_clr_pri", 32'(depth_cnt), 0);

    // Parity vectors (observed after the edge in either build)
    pv_in[0] = 25'h0000001; pv_exp[0] = 5'b00001;
    pv_in[1] = 25'h0000021; pv_exp[1] = 5'b00000;
    pv_in[2] = 25'h1FFFFFF; pv_exp[2] = 5'b11111;
    pv_in[3] = 25'h0000010; pv_exp[3] = 5'b10000;
    pv_in[4] = 25'h0108421; pv_exp[4] = 5'b00001;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, pv_in[i]);
      check($sformatf("par_vec%0d", i), 32'(parity_out), 32'(pv_exp[i]));
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 75),
           ($urandom_range(0, 99) < 4),
           ($urandom_range(0, 99) < 80),
           ($urandom_range(0, 99) < 3),
           25'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/colparity_seq_core.md
Name: colparity_seq_core

Overview:
- Sequencing and parity core for the ColParity datapath. It operates on a 25-bit state, a 5x5 array of single bits.
- Provides a 25-step lane counter, a 6-bit block/depth counter, and a combinational 5-column parity generator.
- The ColParity controller drives the counter enables and clears. The datapath consumes the lane index, the carry-outs and the column parity.

Parameters:
- LANES, 25, number of lane steps; the lane counter runs 0..LANES-1.
- DEPTH_W, 6, width of the depth counter; it runs 0..2^DEPTH_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset; clears both counters and the parity register (when present)
- state_in  input  25  state word; bit index = 5*y + x, x = column 0..4, y = row 0..4
- parity_out  output  5  column parity; bit x covers column x
- lane_en  input  1  lane counter increment enable
- lane_clr  input  1  synchronous lane counter clear
- lane_cnt  output  5  current lane index
- lane_co  output  1  lane counter carry-out
- depth_en  input  1  depth counter increment enable
- depth_clr  input  1  synchronous depth counter clear
- depth_cnt  output  DEPTH_W  current depth count
- depth_co  output  1  depth counter carry-out

Behaviour:
- All registers update on the rising edge of clk. No asynchronous logic.
- Lane counter, per-edge priority:
  - rst or lane_clr: set to 0.
  - else lane_en with lane_cnt==LANES-1: wrap to 0.
  - else lane_en: increment by 1.
  - else: hold.
- lane_cnt never exceeds LANES-1. The reset value of lane_cnt is 0.
- lane_co = (lane_cnt==LANES-1). It is combinational, independent of lane_en, and its reset value is 0.
- Depth counter uses the same priority order: rst/depth_clr, then depth_en increment, then hold.
  - Natural wrap from 2^DEPTH_W-1 to 0.
  - Reset value 0.
- depth_co = (depth_cnt==all ones). It is combinational, independent of depth_en, and its reset value is 0.
- Counters are fully independent. Clear asserted together with enable gives clear. rst asserted mid-count gives 0 on the next edge.
- Parity: parity_out[x] = XOR over y=0..4 of state_in[5*y+x].
  - Pure combinational: zero latency, no clock or reset dependence.
  - X or Z inputs propagate as X. No masking.
- state_in is not registered inside this block; the caller holds it stable.

Optional Feature:
- Macro: COLPARITY_PARITY_REG_EN.
- Defined: parity_out is a 5-bit register loaded every clock with the column parity of state_in.
  - Latency is 1 cycle.
  - rst clears it to 5'b00000.
- Undefined (default): parity_out is combinational as specified above and has no reset value.
- Counter behaviour is identical in both builds.

Test Plan:
- Reset: hold rst for 2 cycles with lane_en=depth_en=1 -> lane_cnt=0, depth_cnt=0, lane_co=0, depth_co=0.
- Lane sweep: release rst, lane_en=1 for 24 cycles -> lane_cnt=24 and lane_co=1. One more cycle -> lane_cnt=0, lane_co=0. With lane_en=0 the count holds.
- Clear priority: lane_cnt=10, lane_clr=1 and lane_en=1 on the same edge -> lane_cnt=0. Same check for depth_clr at depth_cnt=37 -> 0.
- Depth wrap: depth_en=1 for 63 cycles -> depth_cnt=63 and depth_co=1. Next edge -> depth_cnt=0, depth_co=0. Assert rst at depth_cnt=20 -> 0.
- Parity vectors:
  - state_in=25'h0000001 -> 5'b00001
  - 25'h0000021 -> 5'b00000
  - 25'h1FFFFFF -> 5'b11111
  - 25'h0000010 -> 5'b10000
  - 25'h0108421 -> 5'b00001
- With COLPARITY_PARITY_REG_EN defined: the parity vectors appear one cycle after state_in is applied, and rst drives parity_out to 5'b00000.
